// File: rtl/unpack_pkg.sv
// Shared types and constants for the 128-to-64 word unpacker.
// Optional feature macro: UNPACK_STATS_EN (adds completed-word counter to word_unpacker).
package unpack_pkg;

    // Default assembled-word width used by the compression datapath.
    localparam int DEFAULT_WIDTH = 128;

    // Beat position within the head word.
    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } beat_state_t;

    // One FIFO entry: mode flag above the word. word_fifo stores entries
    // flattened in exactly this bit order, so {full, word} packs into it.
    typedef struct packed {
        logic                     full;
        logic [DEFAULT_WIDTH-1:0] word;
    } fifo_entry_t;

endpackage

// File: rtl/word_fifo.sv
// Small word FIFO for word_unpacker: storage, read/write pointers and
// occupancy count. Head entry is read combinationally so the beat mux
// downstream sees it in the same cycle. Flush has priority over push/pop.
module word_fifo
    import unpack_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH + 1,
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_entry,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Entry storage; contents need no reset since the count gates visibility.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            mem_reg[wr_ptr_reg] <= i_entry;
        end
    end

    // Occupancy update: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        if (i_push && !i_pop) begin
            count_next = count_reg + CNT_W'(1);
        end else if (!i_push && i_pop) begin
            count_next = count_reg - CNT_W'(1);
        end
    end

    // Pointers and count; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (i_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (i_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign o_head  = mem_reg[rd_ptr_reg];
    assign o_count = count_reg;

endmodule

// File: rtl/word_unpacker.sv
// Word unpacker: buffers assembled TOTAL_WIDTH words and emits them as
// HALF_WIDTH beats, lower half first. Full-word entries produce two beats,
// half-word entries only the lower half.
// Optional feature macro: UNPACK_STATS_EN adds o_word_cnt, a wrapping count
// of last-beat transfers, cleared by reset and flush.
module word_unpacker
    import unpack_pkg::*;
#(
    parameter int  TOTAL_WIDTH = DEFAULT_WIDTH,
    parameter int  DEPTH       = 2,
    localparam int HALF_WIDTH  = TOTAL_WIDTH / 2,
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [TOTAL_WIDTH-1:0] i_word,
    input  logic                   i_full_word,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [HALF_WIDTH-1:0]  o_half,
    output logic                   o_last,
`ifdef UNPACK_STATS_EN
    output logic [15:0]            o_word_cnt,
`endif
    output logic [CNT_W-1:0]       o_count
);

    beat_state_t          state_reg;
    logic [TOTAL_WIDTH:0] head;
    logic                 head_full;
    logic [CNT_W-1:0]     count;
    logic                 push;
    logic                 pop;
    logic                 beat_xfer;

    // Ready depends only on stored occupancy, never on this cycle's handshakes.
    assign o_ready   = (count < CNT_W'(DEPTH));
    assign o_valid   = (count != '0);
    assign o_count   = count;
    assign head_full = head[TOTAL_WIDTH];
    assign beat_xfer = o_valid && i_ready;

    // Flush wins over both sides of the FIFO; the offered word is dropped.
    assign push = i_valid && o_ready && !i_flush;
    assign pop  = beat_xfer && ((state_reg == S_HIGH) || !head_full) && !i_flush;

    word_fifo #(
        .WIDTH (TOTAL_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_flush (i_flush),
        .i_push  (push),
        .i_pop   (pop),
        .i_entry ({i_full_word, i_word}),
        .o_head  (head),
        .o_count (count)
    );

    // Beat-position FSM: a full word visits S_HIGH before its pop.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= S_LOW;
        end else if (i_flush) begin
            state_reg <= S_LOW;
        end else if (beat_xfer) begin
            if ((state_reg == S_LOW) && head_full) begin
                state_reg <= S_HIGH;
            end else begin
                state_reg <= S_LOW;
            end
        end
    end

    // Beat mux from head and state; zero while empty.
    always_comb begin
        o_half = '0;
        o_last = 1'b0;
        if (o_valid) begin
            if (state_reg == S_HIGH) begin
                o_half = head[TOTAL_WIDTH-1:HALF_WIDTH];
                o_last = 1'b1;
            end else begin
                o_half = head[HALF_WIDTH-1:0];
                o_last = !head_full;
            end
        end
    end

`ifdef UNPACK_STATS_EN
    logic [15:0] word_cnt_reg;

    // Completed-word counter; flush clears it even on a last-beat cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            word_cnt_reg <= '0;
        end else if (i_flush) begin
            word_cnt_reg <= '0;
        end else if (beat_xfer && o_last) begin
            word_cnt_reg <= word_cnt_reg + 16'd1;
        end
    end

    assign o_word_cnt = word_cnt_reg;
`endif

endmodule

// File: tb/tb_word_unpacker.sv
// Directed self-checking bench for word_unpacker (DEPTH=2, 128-bit words).
module tb_word_unpacker;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_rdy;
    logic [127:0] word;
    logic         full_word;
    logic         out_valid;
    logic         out_rdy;
    logic [63:0]  half;
    logic         last;
    logic [1:0]   count;
`ifdef UNPACK_STATS_EN
    logic [15:0]  word_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    word_unpacker #(.TOTAL_WIDTH(128), .DEPTH(2)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_flush     (flush),
        .i_valid     (in_valid),
        .o_ready     (in_rdy),
        .i_word      (word),
        .i_full_word (full_word),
        .o_valid     (out_valid),
        .i_ready     (out_rdy),
        .o_half      (half),
        .o_last      (last),
`ifdef UNPACK_STATS_EN
        .o_word_cnt  (word_cnt),
`endif
        .o_count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; land 1 ns after the edge, then let inputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; word = '0; full_word = 1'b0; out_rdy = 1'b0;
        #12;
        rst_n = 1'b1;
        step();
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_rdy); end
        n_cmp++; if (half !== 64'h0 || last !== 1'b0) begin n_err++; $display("FAIL reset_half_last: got %h/%b want 0/0", half, last); end
`ifdef UNPACK_STATS_EN
        n_cmp++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL reset_wcnt: got %0d want 0", word_cnt); end
`endif
        $display("test_reset: done");
    endtask

    task automatic test_full_word();
        out_rdy = 1'b1; in_valid = 1'b1; full_word = 1'b1;
        word = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_latency: got valid=%b want 1", out_valid); end
        n_cmp++; if (half !== 64'h5555_5555_5555_5555 || last !== 1'b0) begin n_err++; $display("FAIL full_beat1: got %h/%b want 5555555555555555/0", half, last); end
        $display("beat: half=%h last=%b", half, last);
        step(); #1;
        n_cmp++; if (half !== 64'hAAAA_AAAA_AAAA_AAAA || last !== 1'b1) begin n_err++; $display("FAIL full_beat2: got %h/%b want aaaaaaaaaaaaaaaa/1", half, last); end
        $display("beat: half=%h last=%b", half, last);
        step(); #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL full_drained: got valid=%b count=%0d want 0/0", out_valid, count); end
`ifdef UNPACK_STATS_EN
        n_cmp++; if (word_cnt !== 16'd1) begin n_err++; $display("FAIL full_wcnt: got %0d want 1", word_cnt); end
`endif
    endtask

    task automatic test_half_word();
        out_rdy = 1'b1; in_valid = 1'b1; full_word = 1'b0; word = 128'h1234;
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1 || half !== 64'h1234 || last !== 1'b1) begin n_err++; $display("FAIL half_beat: got v=%b %h/%b want 1 0000000000001234/1", out_valid, half, last); end
        $display("beat: half=%h last=%b", half, last);
        step(); #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL half_drained: got valid=%b count=%0d want 0/0", out_valid, count); end
`ifdef UNPACK_STATS_EN
        n_cmp++; if (word_cnt !== 16'd2) begin n_err++; $display("FAIL half_wcnt: got %0d want 2", word_cnt); end
`endif
    endtask

    task automatic test_fill_stalled();
        logic [63:0] exp_beats [6];
        exp_beats = '{64'h1111_0000_0000_0001, 64'h1111_0000_0000_0002,
                      64'h2222_0000_0000_0001, 64'h2222_0000_0000_0002,
                      64'h3333_0000_0000_0001, 64'h3333_0000_0000_0002};
        out_rdy = 1'b0; full_word = 1'b1; in_valid = 1'b1;
        word = {exp_beats[1], exp_beats[0]};
        step();
        word = {exp_beats[3], exp_beats[2]};
        step(); #1;
        n_cmp++; if (in_rdy !== 1'b0 || count !== 2'd2) begin n_err++; $display("FAIL fill_full: got ready=%b count=%0d want 0/2", in_rdy, count); end
        word = {exp_beats[5], exp_beats[4]};
        step(); #1;
        n_cmp++; if (count !== 2'd2 || in_rdy !== 1'b0) begin n_err++; $display("FAIL fill_hold3: got ready=%b count=%0d want 0/2", in_rdy, count); end
        out_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++;
            if (out_valid !== 1'b1 || half !== exp_beats[i] || last !== i[0]) begin
                n_err++;
                $display("FAIL fill_beat%0d: got v=%b %h/%b want 1 %h/%b", i, out_valid, half, last, exp_beats[i], i[0]);
            end
            $display("beat: half=%h last=%b", half, last);
            step();
            // Third word is taken on the edge after the first word pops.
            if (i == 2) in_valid = 1'b0;
        end
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL fill_drained: got valid=%b count=%0d want 0/0", out_valid, count); end
`ifdef UNPACK_STATS_EN
        n_cmp++; if (word_cnt !== 16'd5) begin n_err++; $display("FAIL fill_wcnt: got %0d want 5", word_cnt); end
`endif
    endtask

    task automatic test_mid_word_stall();
        out_rdy = 1'b0; full_word = 1'b1; in_valid = 1'b1;
        word = 128'hCAFE_F00D_DEAD_BEEF_0123_4567_89AB_CDEF;
        step();
        in_valid = 1'b0;
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if (half !== 64'hCAFE_F00D_DEAD_BEEF || last !== 1'b1 || count !== 2'd1) begin
                n_err++;
                $display("FAIL stall_cyc%0d: got %h/%b count=%0d want cafef00ddeadbeef/1 count=1", i, half, last, count);
            end
            step();
        end
        out_rdy = 1'b1;
        step(); #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0) begin n_err++; $display("FAIL stall_release: got valid=%b count=%0d want 0/0", out_valid, count); end
        $display("test_mid_word_stall: done");
    endtask

    task automatic test_flush();
        out_rdy = 1'b0; full_word = 1'b1; in_valid = 1'b1;
        word = 128'h5000_0000_0000_0002_5000_0000_0000_0001;
        step();
        word = 128'h6000_0000_0000_0002_6000_0000_0000_0001;
        step();
        in_valid = 1'b0;
        out_rdy = 1'b1;
        step();
        out_rdy = 1'b0;
        #1;
        n_cmp++; if (half !== 64'h5000_0000_0000_0002 || count !== 2'd2) begin n_err++; $display("FAIL flush_pre: got %h count=%0d want 5000000000000002 count=2", half, count); end
        flush = 1'b1; in_valid = 1'b1;
        word = 128'h7000_0000_0000_0002_7000_0000_0000_0001;
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0 || in_rdy !== 1'b1) begin n_err++; $display("FAIL flush_clear: got valid=%b count=%0d ready=%b want 0/0/1", out_valid, count, in_rdy); end
`ifdef UNPACK_STATS_EN
        n_cmp++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL flush_wcnt: got %0d want 0", word_cnt); end
`endif
        step(); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped: got valid=%b want 0", out_valid); end
        out_rdy = 1'b1; in_valid = 1'b1;
        word = 128'h8000_0000_0000_0002_8000_0000_0000_0001;
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (half !== 64'h8000_0000_0000_0001 || last !== 1'b0) begin n_err++; $display("FAIL flush_next_low: got %h/%b want 8000000000000001/0", half, last); end
        step();
        step(); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_next_drain: got valid=%b want 0", out_valid); end
        $display("test_flush: done");
    endtask

    task automatic test_async_reset();
        out_rdy = 1'b0; full_word = 1'b1; in_valid = 1'b1;
        word = 128'h9999_0000_0000_0002_9999_0000_0000_0001;
        step();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL areset_pre: got valid=%b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 2'd0 || half !== 64'h0) begin n_err++; $display("FAIL areset_now: got valid=%b count=%0d half=%h want 0/0/0", out_valid, count, half); end
`ifdef UNPACK_STATS_EN
        n_cmp++; if (word_cnt !== 16'd0) begin n_err++; $display("FAIL areset_wcnt: got %0d want 0", word_cnt); end
`endif
        step();
        rst_n = 1'b1;
        step(); #1;
        n_cmp++; if (out_valid !== 1'b0 || in_rdy !== 1'b1) begin n_err++; $display("FAIL areset_after: got valid=%b ready=%b want 0/1", out_valid, in_rdy); end
        $display("test_async_reset: done");
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_half_word();
        test_fill_stalled();
        test_mid_word_stall();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
